// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a pixel-rate enable, registered sync/video outputs
// and a small set of test patterns selected per frame.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] mode,
    input  logic       mode_valid,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_en,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 2) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic [2:0]       pending_mode;
    logic [2:0]       active_mode;
    logic             h_last;
    logic             v_last;
    logic             in_hs;
    logic             in_vs;
    logic             vis;
    logic [12:0]      x_times8;
    logic [2:0]       bar_idx;
    logic [2:0]       pat_r;
    logic [2:0]       pat_g;
    logic [1:0]       pat_b;

    assign h_last   = (h_cnt == 10'(H_TOTAL - 1));
    assign v_last   = (v_cnt == 10'(V_TOTAL - 1));
    assign in_hs    = (h_cnt >= 10'(H_ACTIVE + H_FP)) && (h_cnt <= 10'(H_ACTIVE + H_FP + H_SYNC - 1));
    assign in_vs    = (v_cnt >= 10'(V_ACTIVE + V_FP)) && (v_cnt <= 10'(V_ACTIVE + V_FP + V_SYNC - 1));
    assign vis      = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    assign x_times8 = {h_cnt, 3'b000};
    assign bar_idx  = 3'(x_times8 / 13'(H_ACTIVE));

    // Pixel enable is registered so it is a clean one-clock pulse on the CLK_DIV-th edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            h_cnt <= h_last ? '0 : h_cnt + 10'd1;
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end
        end
    end

    // A strobe on the boundary pix_en lands in pending_mode after active_mode samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_mode <= '0;
            active_mode  <= '0;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick <= pix_en && h_last && v_last;
            if (mode_valid) begin
                pending_mode <= mode;
            end
            if (pix_en && h_last && v_last) begin
                active_mode <= pending_mode;
            end
        end
    end

    always_comb begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        unique case (active_mode)
            3'd0: ;
            3'd1: pat_r = 3'd7;
            3'd2: pat_g = 3'd7;
            3'd3: pat_b = 2'd3;
            3'd4: begin
                pat_r = {3{bar_idx[2]}};
                pat_g = {3{bar_idx[1]}};
                pat_b = {2{bar_idx[0]}};
            end
            3'd5: begin
                if (h_cnt[5] ^ v_cnt[5]) begin
                    pat_r = 3'd7;
                    pat_g = 3'd7;
                    pat_b = 2'd3;
                end
            end
            3'd6: begin
                pat_r = h_cnt[9:7];
                pat_g = h_cnt[9:7];
                pat_b = h_cnt[9:8];
            end
            3'd7: begin
                if (h_cnt == 10'd0 || h_cnt == 10'(H_ACTIVE - 1) ||
                    v_cnt == 10'd0 || v_cnt == 10'(V_ACTIVE - 1)) begin
                    pat_r = 3'd7;
                    pat_g = 3'd7;
                    pat_b = 2'd3;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync    <= ~HS_POL;
            vsync    <= ~VS_POL;
            video_on <= 1'b0;
            x        <= '0;
            y        <= '0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else if (pix_en) begin
            hsync    <= in_hs ? HS_POL : ~HS_POL;
            vsync    <= in_vs ? VS_POL : ~VS_POL;
            video_on <= vis;
            x        <= h_cnt;
            y        <= v_cnt;
            red      <= vis ? pat_r : 3'd0;
            green    <= vis ? pat_g : 3'd0;
            blue     <= vis ? pat_b : 2'd0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: shrunken raster, every output compared each clock against
// a pixel-index model derived from the clock count since reset release.
module tb_vga_timing_gen;

    localparam int HA  = 136;
    localparam int HF  = 4;
    localparam int HSW = 6;
    localparam int HB  = 2;
    localparam int VA  = 36;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam bit HS_P = 1'b1;
    localparam bit VS_P = 1'b0;
    localparam int D   = 2;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int FT  = HT * VT;
    localparam int LINE_CLK = HT * D;

    logic       clk;
    logic       rst_n;
    logic [2:0] mode;
    logic       mode_valid;
    logic       hsync;
    logic       vsync;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_en;
    logic       frame_tick;

    int checks;
    int failures;
    int k;
    int st_edge[$];
    int st_mode[$];

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HS_P), .VS_POL(VS_P), .CLK_DIV(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .mode_valid(mode_valid),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .video_on(video_on), .x(x), .y(y), .pix_en(pix_en), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%0d expected=%0d", tag, k, got, exp);
        end
    endtask

    // Mode shown in frame f: last strobe sampled strictly before that frame's boundary edge.
    function automatic int mode_for_frame(input int f);
        int md = 0;
        if (f == 0) return 0;
        foreach (st_edge[i]) begin
            if (st_edge[i] < f * FT * D + 1) md = st_mode[i];
        end
        return md;
    endfunction

    function automatic logic [7:0] exp_colour(input int md, input int px, input int py);
        logic [2:0] idx;
        logic [7:0] white = 8'hff;
        case (md)
            1: return {3'd7, 3'd0, 2'd0};
            2: return {3'd0, 3'd7, 2'd0};
            3: return {3'd0, 3'd0, 2'd3};
            4: begin
                idx = 3'((px * 8) / HA);
                return {{3{idx[2]}}, {3{idx[1]}}, {2{idx[0]}}};
            end
            5: return ((((px / 32) + (py / 32)) % 2) == 1) ? white : 8'h00;
            6: return {3'((px / 128) % 8), 3'((px / 128) % 8), 2'((px / 256) % 4)};
            7: return (px == 0 || px == HA - 1 || py == 0 || py == VA - 1) ? white : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_reset_vals();
        check("rst_hsync", hsync, !HS_P);
        check("rst_vsync", vsync, !VS_P);
        check("rst_video_on", video_on, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", {red, green, blue}, 0);
        check("rst_pix_en", pix_en, 0);
        check("rst_frame_tick", frame_tick, 0);
    endtask

    task automatic check_all();
        int m, h, v, f;
        logic ehs, evs, evo, eft;
        logic [7:0] ecol;
        check("pix_en", pix_en, (k % D) == 0);
        if (k < D + 1) begin
            h = 0; v = 0; ehs = !HS_P; evs = !VS_P; evo = 0; eft = 0; ecol = 0;
        end else begin
            m   = (k - 1) / D - 1;
            h   = m % HT;
            v   = (m / HT) % VT;
            f   = m / FT;
            ehs = (h >= HA + HF && h < HA + HF + HSW) ? HS_P : !HS_P;
            evs = (v >= VA + VF && v < VA + VF + VSW) ? VS_P : !VS_P;
            evo = (h < HA) && (v < VA);
            ecol = evo ? exp_colour(mode_for_frame(f), h, v) : 8'h00;
            eft = ((k - 1) % D == 0) && ((m + 1) % FT == 0);
        end
        check("hsync", hsync, ehs);
        check("vsync", vsync, evs);
        check("video_on", video_on, evo);
        check("x", x, h);
        check("y", y, v);
        check("colour", {red, green, blue}, ecol);
        check("frame_tick", frame_tick, eft);
    endtask

    // Drive at a falling edge, advance one rising edge, check at the next falling edge.
    task automatic tick(input logic mv, input logic [2:0] md);
        mode_valid = mv;
        mode       = md;
        @(posedge clk);
        k++;
        if (mv) begin
            st_edge.push_back(k);
            st_mode.push_back(int'(md));
        end
        @(negedge clk);
        mode_valid = 1'b0;
        check_all();
    endtask

    // Tick until the next tick is sampled on edge tgt.
    task automatic run_to(input int tgt, input bit rnd);
        while (k < tgt - 1) begin
            tick(rnd && ($urandom_range(0, 2999) == 0), 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        k = 0;
        st_edge.delete();
        st_mode.delete();
    endtask

    initial begin
        int kb1, kb2, kb3, rl;
        checks = 0; failures = 0; k = 0;
        rst_n = 1'b0; mode = 3'd0; mode_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        release_reset();

        kb1 = FT * D + 1;
        kb2 = 2 * FT * D + 1;
        kb3 = 3 * FT * D + 1;

        // Frame 0: colour bars requested mid-frame; a strobe exactly on the boundary edge.
        run_to(20 * LINE_CLK, 0);
        tick(1'b1, 3'd4);
        run_to(kb1, 0);
        tick(1'b1, 3'd5);
        // Frame 1 shows bars, frame 2 the checkerboard; two strobes in frame 2, last wins.
        run_to(kb2 + 10 * LINE_CLK, 0);
        tick(1'b1, 3'($urandom_range(1, 3)));
        run_to(kb2 + 30 * LINE_CLK, 1);
        tick(1'b1, 3'd7);
        // Frame 3: border, random strobes, then reset mid-frame at a random pixel.
        rl = $urandom_range(5, 35);
        run_to(kb3 + rl * LINE_CLK + $urandom_range(0, LINE_CLK - 1), 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        repeat (3) begin
            @(negedge clk);
            check_reset_vals();
        end
        release_reset();

        // Restart from (0,0) with mode 0; gradient requested for the next frame.
        run_to(15 * LINE_CLK, 0);
        tick(1'b1, 3'd6);
        run_to(kb1, 0);
        run_to(kb1 + 40 * LINE_CLK, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
